// File: rtl/hazard_sb_if.sv
// hazard_sb_if: groups the pipeline-side signals of the hazard/scoreboard unit.
//   Parameters: XLEN (forwarded data width), RA_W (register address width).
//   master modport: the pipeline. It drives the EX/MEM/WB stage information
//                   and receives the forward, stall and flush controls.
//   slave modport:  hazard_sb itself.
//   clk and rstn are plain ports on hazard_sb and are not part of this bundle.
interface hazard_sb_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);

  // EX stage
  logic [RA_W-1:0] ex_ra0;
  logic [RA_W-1:0] ex_ra1;
  logic            ex_re0;
  logic            ex_re1;
  logic [RA_W-1:0] ex_wa;
  logic            ex_long;
  logic [1:0]      pc_sel_ex;

  // MEM stage
  logic [RA_W-1:0] mem_wa;
  logic            mem_we;
  logic [1:0]      mem_wd_sel;
  logic [XLEN-1:0] mem_alu;
  logic [XLEN-1:0] mem_pc4;
  logic [XLEN-1:0] mem_imm;

  // WB stage
  logic [RA_W-1:0] wb_wa;
  logic            wb_we;
  logic [XLEN-1:0] wb_wd;

  // Long (mul/div) unit completion
  logic            lu_done;
  logic [RA_W-1:0] lu_wa;

  // Hazard unit outputs
  logic            fwd0_en;
  logic            fwd1_en;
  logic [XLEN-1:0] fwd0_data;
  logic [XLEN-1:0] fwd1_data;
  logic            stall_if;
  logic            stall_id;
  logic            stall_ex;
  logic            flush_id;
  logic            flush_ex;
  logic            flush_mem;

  modport master (
    output ex_ra0, ex_ra1, ex_re0, ex_re1, ex_wa, ex_long, pc_sel_ex,
    output mem_wa, mem_we, mem_wd_sel, mem_alu, mem_pc4, mem_imm,
    output wb_wa, wb_we, wb_wd, lu_done, lu_wa,
    input  fwd0_en, fwd1_en, fwd0_data, fwd1_data,
    input  stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem
  );

  modport slave (
    input  ex_ra0, ex_ra1, ex_re0, ex_re1, ex_wa, ex_long, pc_sel_ex,
    input  mem_wa, mem_we, mem_wd_sel, mem_alu, mem_pc4, mem_imm,
    input  wb_wa, wb_we, wb_wd, lu_done, lu_wa,
    output fwd0_en, fwd1_en, fwd0_data, fwd1_data,
    output stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem
  );

endinterface

// File: rtl/hazard_sb.sv
// hazard_sb: operand forwarding, load-use bubbles, and a busy-register
// scoreboard for one multi-cycle (mul/div) unit.
//   Parameters: XLEN data width, RA_W register address width,
//               LU_BUBBLES bubbles per load-use hazard (legal range 1..3).
//   Ports: clk  - rising-edge clock
//          rstn - asynchronous active-low reset
//          bus  - hazard_sb_if.slave carrying the stage inputs and the
//                 fwd*/stall_*/flush_* outputs
//   Forwarding is purely combinational. Stall and flush are combinational
//   from the inputs plus two registers: the bubble counter and the busy vector.
module hazard_sb #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int LU_BUBBLES = 1
) (
  input logic         clk,
  input logic         rstn,
  hazard_sb_if.slave  bus
);

  localparam int NREG = 2 ** RA_W;
  localparam logic [1:0] BUB_LOAD = 2'(LU_BUBBLES - 1);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] done_mask;
  logic [NREG-1:0] set_mask;
  logic [1:0]      bub_cnt;

  logic [XLEN-1:0] mem_val;
  logic            mem_hit0, mem_hit1, wb_hit0, wb_hit1;
  logic            mem_is_load;
  logic            lu_hit;
  logic            lu_stall, raw_stall, struct_stall, stall;
  logic            set_long;

  // Forwarding. A load result is not yet available in MEM, so a load in MEM
  // never forwards; that case is handled by the load-use bubble instead.
  always_comb begin
    mem_is_load = (bus.mem_wd_sel == 2'b10);
    case (bus.mem_wd_sel)
      2'b00:   mem_val = bus.mem_alu;
      2'b01:   mem_val = bus.mem_pc4;
      2'b11:   mem_val = bus.mem_imm;
      default: mem_val = '0;
    endcase

    mem_hit0 = bus.ex_re0 && bus.mem_we && !mem_is_load &&
               (bus.mem_wa == bus.ex_ra0) && (bus.ex_ra0 != '0);
    mem_hit1 = bus.ex_re1 && bus.mem_we && !mem_is_load &&
               (bus.mem_wa == bus.ex_ra1) && (bus.ex_ra1 != '0);
    wb_hit0  = bus.ex_re0 && bus.wb_we &&
               (bus.wb_wa == bus.ex_ra0) && (bus.ex_ra0 != '0);
    wb_hit1  = bus.ex_re1 && bus.wb_we &&
               (bus.wb_wa == bus.ex_ra1) && (bus.ex_ra1 != '0);
  end

  assign bus.fwd0_en   = mem_hit0 | wb_hit0;
  assign bus.fwd1_en   = mem_hit1 | wb_hit1;
  assign bus.fwd0_data = mem_hit0 ? mem_val : (wb_hit0 ? bus.wb_wd : '0);
  assign bus.fwd1_data = mem_hit1 ? mem_val : (wb_hit1 ? bus.wb_wd : '0);

  // Hazard detection. RAW-long uses the registered busy vector, so a reader
  // stays stalled through the completion cycle and is released one cycle
  // later. The structural check treats the register completing this cycle as
  // already free, so a new long op can issue alongside a completion, and the
  // set-over-clear rule below then keeps the register busy.
  always_comb begin
    done_mask = bus.lu_done ? (NREG'(1) << bus.lu_wa) : '0;

    lu_hit = bus.mem_we && mem_is_load && (bus.mem_wa != '0) &&
             ((bus.ex_re0 && (bus.ex_ra0 == bus.mem_wa)) ||
              (bus.ex_re1 && (bus.ex_ra1 == bus.mem_wa)));
    lu_stall = (bub_cnt != 2'd0) || lu_hit;

    raw_stall = (bus.ex_re0 && (bus.ex_ra0 != '0) && busy[bus.ex_ra0]) ||
                (bus.ex_re1 && (bus.ex_ra1 != '0) && busy[bus.ex_ra1]);
    struct_stall = bus.ex_long && (|(busy & ~done_mask));

    stall    = lu_stall || raw_stall || struct_stall;
    set_long = bus.ex_long && (bus.ex_wa != '0) && !stall;
    set_mask = set_long ? (NREG'(1) << bus.ex_wa) : '0;
  end

  assign bus.stall_if  = stall;
  assign bus.stall_id  = stall;
  assign bus.stall_ex  = stall;
  assign bus.flush_mem = stall;
  // A redirect waits until the stall is over, so the branch in EX is not lost.
  assign bus.flush_id  = (bus.pc_sel_ex != 2'b00) && !stall;
  assign bus.flush_ex  = (bus.pc_sel_ex != 2'b00) && !stall;

  // Bubble counter. Once a load-use hazard is seen, the counter holds off
  // fresh detection until all LU_BUBBLES bubbles have been issued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bub_cnt <= 2'd0;
    end else if (bub_cnt != 2'd0) begin
      bub_cnt <= bub_cnt - 2'd1;
    end else if (lu_hit) begin
      bub_cnt <= BUB_LOAD;
    end
  end

  // Busy vector. The clear is applied first and the set second, so a set of
  // the same register wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~done_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_hazard_sb.sv
// tb_hazard_sb: directed self-checking bench for hazard_sb (LU_BUBBLES = 2).
//   Drives the interface from one initial block and compares the outputs
//   with hand-computed values through checkOutput.
module tb_hazard_sb;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk;
  logic rstn;
  int   checkCount;
  int   passCount;

  hazard_sb_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

  hazard_sb #(.XLEN(XLEN), .RA_W(RA_W), .LU_BUBBLES(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // The clock free-runs with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the EX-stage and control inputs.
  task automatic applyStimulus(input logic re0, input logic [RA_W-1:0] ra0,
                               input logic re1, input logic [RA_W-1:0] ra1,
                               input logic lng, input logic [RA_W-1:0] wa,
                               input logic [1:0] pcsel,
                               input logic ludone, input logic [RA_W-1:0] luwa);
    bus.ex_re0    = re0;
    bus.ex_ra0    = ra0;
    bus.ex_re1    = re1;
    bus.ex_ra1    = ra1;
    bus.ex_long   = lng;
    bus.ex_wa     = wa;
    bus.pc_sel_ex = pcsel;
    bus.lu_done   = ludone;
    bus.lu_wa     = luwa;
  endtask

  // Drive the MEM/WB write-back information.
  task automatic applyWriteback(input logic mwe, input logic [RA_W-1:0] mwa,
                                input logic [1:0] msel,
                                input logic wwe, input logic [RA_W-1:0] wwa);
    bus.mem_we     = mwe;
    bus.mem_wa     = mwa;
    bus.mem_wd_sel = msel;
    bus.wb_we      = wwe;
    bus.wb_wa      = wwa;
  endtask

  // Return all inputs to an idle state.
  task automatic applyIdle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0);
    applyWriteback(1'b0, 5'd0, 2'b00, 1'b0, 5'd0);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Check the shared stall/flush_mem value plus the redirect flushes.
  task automatic checkStall(input string tag, input logic st, input logic fl);
    checkOutput({tag, "_stall_if"},  XLEN'(bus.stall_if),  XLEN'(st));
    checkOutput({tag, "_stall_ex"},  XLEN'(bus.stall_ex),  XLEN'(st));
    checkOutput({tag, "_flush_mem"}, XLEN'(bus.flush_mem), XLEN'(st));
    checkOutput({tag, "_flush_id"},  XLEN'(bus.flush_id),  XLEN'(fl));
  endtask

  // Main directed sequence.
  initial begin
    checkCount = 0;
    passCount  = 0;
    bus.mem_alu = 32'h11;
    bus.mem_pc4 = 32'h44;
    bus.mem_imm = 32'h33;
    bus.wb_wd   = 32'h22;
    applyIdle();
    rstn = 1'b0;
    #12;
    checkStall("reset", 1'b0, 1'b0);
    checkOutput("reset_fwd0_en", XLEN'(bus.fwd0_en), '0);
    rstn = 1'b1;
    tick();

    // MEM has priority over WB, and the selected MEM source is forwarded.
    applyWriteback(1'b1, 5'd5, 2'b00, 1'b1, 5'd5);
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0);
    #1;
    checkOutput("mem_alu_en",   XLEN'(bus.fwd0_en), 32'd1);
    checkOutput("mem_alu_data", bus.fwd0_data, 32'h11);
    bus.mem_wd_sel = 2'b01;
    #1;
    checkOutput("mem_pc4_data", bus.fwd1_data, 32'h44);
    bus.mem_wd_sel = 2'b11;
    #1;
    checkOutput("mem_imm_data", bus.fwd0_data, 32'h33);
    bus.mem_we = 1'b0;
    #1;
    checkOutput("wb_data",      bus.fwd1_data, 32'h22);
    checkOutput("wb_en",        XLEN'(bus.fwd1_en), 32'd1);

    // x0 never forwards, and a load to x0 never stalls.
    applyWriteback(1'b1, 5'd0, 2'b10, 1'b1, 5'd0);
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0);
    #1;
    checkOutput("x0_fwd1_en",   XLEN'(bus.fwd1_en), '0);
    checkOutput("x0_fwd1_data", bus.fwd1_data, '0);
    checkStall("x0_load", 1'b0, 1'b0);
    applyIdle();
    tick();

    // A load-use on x7 gives exactly two bubbles; the load does not forward.
    applyWriteback(1'b1, 5'd7, 2'b10, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0);
    #1;
    checkStall("lu_c0", 1'b1, 1'b0);
    checkOutput("lu_no_fwd", XLEN'(bus.fwd0_en), '0);
    tick();
    applyWriteback(1'b0, 5'd0, 2'b00, 1'b0, 5'd0);
    #1;
    checkStall("lu_c1", 1'b1, 1'b0);
    tick();
    #1;
    checkStall("lu_c2", 1'b0, 1'b0);
    applyIdle();
    tick();

    // A long op to x9 issues, then a reader of x9 stalls until completion.
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 2'b00, 1'b0, 5'd0);
    #1;
    checkStall("long_issue", 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 2'b01, 1'b0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkStall("raw_wait", 1'b1, 1'b0);
      tick();
    end
    bus.lu_done = 1'b1;
    bus.lu_wa   = 5'd9;
    #1;
    checkStall("raw_done_cycle", 1'b1, 1'b0);
    tick();
    bus.lu_done = 1'b0;
    #1;
    checkStall("raw_release", 1'b0, 1'b1);
    checkOutput("raw_release_flush_ex", XLEN'(bus.flush_ex), 32'd1);
    applyIdle();
    tick();

    // A long op to x0 marks nothing busy.
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 2'b00, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0);
    #1;
    checkStall("x0_long", 1'b0, 1'b0);

    // A new long op to x9 alongside the x9 completion keeps x9 busy.
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 2'b00, 1'b0, 5'd0);
    tick();
    applyIdle();
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 2'b00, 1'b1, 5'd9);
    #1;
    checkStall("set_clear_same", 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0);
    #1;
    checkStall("set_wins", 1'b1, 1'b0);

    // A second long op while one is in flight stalls (structural).
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 2'b00, 1'b0, 5'd0);
    #1;
    checkStall("structural", 1'b1, 1'b0);

    // Reset in the middle of a RAW stall drops every output at once.
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0);
    #1;
    checkStall("pre_reset", 1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    checkStall("mid_reset", 1'b0, 1'b0);
    checkOutput("mid_reset_fwd0", XLEN'(bus.fwd0_en), '0);
    #3;
    rstn = 1'b1;
    tick();
    #1;
    checkStall("after_reset", 1'b0, 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
